// File: rtl/blur_frame_sequencer.sv
// Frame sequencer: walks a 3x3 window over a frame held in a synchronous-read RAM,
// feeds one shared kernel instance, and writes each result at the window centre.
module blur_frame_sequencer #(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int ADDR_W     = 16,
    parameter int KERNEL_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [71:0]       win_pixels,
    output logic              win_valid,
    input  logic [7:0]        k_pixel,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] W2_A     = ADDR_W'(2 * IMG_W);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [CW-1:0]     LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     LAST_ROW = RW'(IMG_H - 3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state_q;
    logic [1:0]          phase_q;
    logic [CW-1:0]       col_q;
    logic [RW-1:0]       row_q;
    logic [ADDR_W-1:0]   row_base_q;
    logic [7:0]          col_r0_q;
    logic [7:0]          col_r1_q;
    logic [71:0]         win_q;
    logic                win_valid_q;
    logic [ADDR_W-1:0]   win_addr_q;
    logic                busy_q;
    logic                done_q;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [KERNEL_LAT-1:0] pv_q;
    logic [ADDR_W-1:0]   pa_q [KERNEL_LAT];

    logic [71:0]         win_shift_d;
    logic [ADDR_W-1:0]   addr_p1_d;
    logic [ADDR_W-1:0]   addr_p2_d;
    logic [ADDR_W-1:0]   addr_next_col_d;
    logic [ADDR_W-1:0]   addr_next_row_d;
    logic [ADDR_W-1:0]   centre_d;
    logic                pend_s;

    // Window shifted left by one column with the freshly fetched column at c=2
    always_comb begin
        win_shift_d = win_q;
        for (int r = 0; r < 3; r++) begin
            win_shift_d[(3*r)*8 +: 8]   = win_q[(3*r+1)*8 +: 8];
            win_shift_d[(3*r+1)*8 +: 8] = win_q[(3*r+2)*8 +: 8];
        end
        win_shift_d[23:16] = col_r0_q;
        win_shift_d[47:40] = col_r1_q;
        win_shift_d[71:64] = rd_data;
    end

    // Address arithmetic relative to the current row base (no multiplier needed)
    always_comb begin
        addr_p1_d       = row_base_q + W_A + ADDR_W'(col_q);
        addr_p2_d       = row_base_q + W2_A + ADDR_W'(col_q);
        addr_next_col_d = row_base_q + ADDR_W'(col_q) + ONE_A;
        addr_next_row_d = row_base_q + W_A;
        centre_d        = row_base_q + W_A + ADDR_W'(col_q) - ONE_A;
    end

    // Writes still in flight other than the one leaving the pipe this cycle
    assign pend_s = win_valid_q | (|(pv_q << 1));

    // Sequencer FSM: column fetch phases, window issue, row advance and flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= 2'd0;
            col_q       <= '0;
            row_q       <= '0;
            row_base_q  <= '0;
            col_r0_q    <= 8'd0;
            col_r1_q    <= 8'd0;
            win_q       <= 72'd0;
            win_valid_q <= 1'b0;
            win_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            done_q      <= 1'b0;
            win_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        rd_en_q    <= 1'b1;
                        rd_addr_q  <= '0;
                        phase_q    <= 2'd0;
                        col_q      <= '0;
                        row_q      <= '0;
                        row_base_q <= '0;
                    end
                end
                RUN: begin
                    case (phase_q)
                        2'd0: begin
                            rd_addr_q <= addr_p1_d;
                            phase_q   <= 2'd1;
                        end
                        2'd1: begin
                            col_r0_q  <= rd_data;
                            rd_addr_q <= addr_p2_d;
                            phase_q   <= 2'd2;
                        end
                        2'd2: begin
                            col_r1_q <= rd_data;
                            rd_en_q  <= 1'b0;
                            phase_q  <= 2'd3;
                        end
                        default: begin
                            win_q   <= win_shift_d;
                            phase_q <= 2'd0;
                            if (col_q >= CW'(2)) begin
                                win_valid_q <= 1'b1;
                                win_addr_q  <= centre_d;
                            end
                            if (col_q == LAST_COL) begin
                                col_q <= '0;
                                if (row_q == LAST_ROW) begin
                                    state_q <= FLUSH;
                                    rd_en_q <= 1'b0;
                                end else begin
                                    row_q      <= row_q + RW'(1);
                                    row_base_q <= addr_next_row_d;
                                    rd_en_q    <= 1'b1;
                                    rd_addr_q  <= addr_next_row_d;
                                end
                            end else begin
                                col_q     <= col_q + CW'(1);
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= addr_next_col_d;
                            end
                        end
                    endcase
                end
                FLUSH: begin
                    if (!pend_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write pipeline: valid + centre address matched to the kernel latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q <= '0;
            for (int i = 0; i < KERNEL_LAT; i++) begin
                pa_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= win_valid_q;
            pa_q[0] <= win_addr_q;
            for (int i = 1; i < KERNEL_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pa_q[i] <= pa_q[i-1];
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign win_pixels = win_q;
    assign win_valid  = win_valid_q;
    assign wr_en      = pv_q[KERNEL_LAT-1];
    assign wr_addr    = pa_q[KERNEL_LAT-1];
    // Kernel result passes straight through so it lands in its own write cycle
    assign wr_data    = pv_q[KERNEL_LAT-1] ? k_pixel : 8'd0;

endmodule

// File: tb/tb_blur_frame_sequencer.sv
// Self-checking bench: small frame, source RAM and 1-2-1 kernel models, per-cycle
// expectations derived from the frame schedule and the frame contents.
module tb_blur_frame_sequencer;

    localparam int W  = 8;
    localparam int H  = 5;
    localparam int L  = 3;
    localparam int AW = 16;
    localparam int N  = (H - 2) * W;
    localparam int DONE_N = 4 * N + 2 + L;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, rd_en, win_valid, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [7:0]    rd_data, k_pixel, wr_data;
    logic [71:0]   win_pixels;

    logic [7:0] mem [W*H];
    logic [7:0] kp  [L];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    blur_frame_sequencer #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .KERNEL_LAT(L)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .win_pixels(win_pixels), .win_valid(win_valid), .k_pixel(k_pixel),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    function automatic logic [7:0] kern(input logic [71:0] w);
        logic [31:0] s;
        s = 32'd0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                s = s + 32'(w[(3*r+c)*8 +: 8]) * ((r == 1) ? 32'd2 : 32'd1) * ((c == 1) ? 32'd2 : 32'd1);
        return s[11:4];
    endfunction

    // Source RAM: synchronous read, data the cycle after rd_en
    always @(posedge clk) begin
        if (rd_en && int'(rd_addr) < W * H) rd_data <= mem[int'(rd_addr)];
        else if (rd_en) rd_data <= 8'hxx;
    end

    // Kernel stand-in with L register stages
    always @(posedge clk) begin
        kp[0] <= win_valid ? kern(win_pixels) : 8'd0;
        for (int i = 1; i < L; i++) kp[i] <= kp[i-1];
    end
    assign k_pixel = kp[L-1];

    function automatic int px(input int r, input int c);
        return int'(mem[r * W + c]);
    endfunction

    // Gaussian of the frame neighbourhood around centre (r,c)
    function automatic int ref_blur(input int r, input int c);
        int s;
        s = 4 * px(r, c)
          + 2 * (px(r-1, c) + px(r+1, c) + px(r, c-1) + px(r, c+1))
          + px(r-1, c-1) + px(r-1, c+1) + px(r+1, c-1) + px(r+1, c+1);
        return s / 16;
    endfunction

    function automatic logic [71:0] ref_win(input int r, input int c);
        logic [71:0] w;
        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
                w[(3*rr+cc)*8 +: 8] = mem[(r + rr) * W + (c - 2 + cc)];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " busy"}, 72'(busy), 72'd0);
        chk({tag, " done"}, 72'(done), 72'd0);
        chk({tag, " rd_en"}, 72'(rd_en), 72'd0);
        chk({tag, " rd_addr"}, 72'(rd_addr), 72'd0);
        chk({tag, " win_valid"}, 72'(win_valid), 72'd0);
        chk({tag, " win_pixels"}, win_pixels, 72'd0);
        chk({tag, " wr_en"}, 72'(wr_en), 72'd0);
        chk({tag, " wr_addr"}, 72'(wr_addr), 72'd0);
        chk({tag, " wr_data"}, 72'(wr_data), 72'd0);
    endtask

    // Expected outputs for cycle n of a frame (cycle 0 = start sampled)
    task automatic check_cycle(input int n);
        int k, p, m, r, c;
        bit e_rden, e_wv, e_we;
        k = (n - 1) / 4;
        p = (n - 1) % 4;
        chk($sformatf("busy n=%0d", n), 72'(busy), 72'(n >= 1 && n <= 4 * N + 1 + L));
        chk($sformatf("done n=%0d", n), 72'(done), 72'(n == DONE_N));
        e_rden = (n >= 1) && (n <= 4 * N) && (p != 3);
        chk($sformatf("rd_en n=%0d", n), 72'(rd_en), 72'(e_rden));
        if (e_rden)
            chk($sformatf("rd_addr n=%0d", n), 72'(rd_addr), 72'((k / W + p) * W + k % W));
        m = n - 5;
        e_wv = (m >= 0) && (m % 4 == 0) && (m / 4 < N) && ((m / 4) % W >= 2);
        chk($sformatf("win_valid n=%0d", n), 72'(win_valid), 72'(e_wv));
        if (e_wv)
            chk($sformatf("win_pixels n=%0d", n), win_pixels, ref_win((m / 4) / W, (m / 4) % W));
        m = n - 5 - L;
        e_we = (m >= 0) && (m % 4 == 0) && (m / 4 < N) && ((m / 4) % W >= 2);
        chk($sformatf("wr_en n=%0d", n), 72'(wr_en), 72'(e_we));
        if (e_we) begin
            r = (m / 4) / W + 1;
            c = (m / 4) % W - 1;
            chk($sformatf("wr_addr n=%0d", n), 72'(wr_addr), 72'(r * W + c));
            chk($sformatf("wr_data n=%0d", n), 72'(wr_data), 72'(ref_blur(r, c)));
        end
    endtask

    task automatic begin_frame();
        @(posedge clk); #1;
        start = 1'b1;
    endtask

    task automatic run_frame(input int extra_start, input bit chain, input int stop_n);
        for (int n = 1; n <= stop_n; n++) begin
            @(posedge clk); #1;
            start = (n == extra_start) || (chain && n == DONE_N);
            @(negedge clk);
            check_cycle(n);
        end
    endtask

    task automatic idle_check();
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_cycle(DONE_N + j);
        end
    endtask

    task automatic load_random();
        for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom_range(255, 0));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < W * H; i++) mem[i] = 8'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("idle");

        // Ramp frame: pixel = row*W + col
        begin_frame();
        run_frame(0, 1'b0, DONE_N);
        idle_check();

        // Two random frames back to back, second started in the done cycle
        load_random();
        begin_frame();
        run_frame(0, 1'b1, DONE_N);
        load_random();
        run_frame(0, 1'b0, DONE_N);
        idle_check();

        // Random frame with a start pulse while busy
        load_random();
        begin_frame();
        run_frame($urandom_range(4 * N + 1 + L, 1), 1'b0, DONE_N);
        idle_check();

        // Impulse at (2,3)
        for (int i = 0; i < W * H; i++) mem[i] = 8'd0;
        mem[2 * W + 3] = 8'd255;
        begin_frame();
        run_frame(0, 1'b0, DONE_N);
        idle_check();

        // Reset mid-frame, then a full restart
        load_random();
        begin_frame();
        run_frame(0, 1'b0, 40);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_zero("rst async");
        @(negedge clk);
        check_zero("rst hold1");
        @(posedge clk);
        @(negedge clk);
        check_zero("rst hold2");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check_zero("post rst");
        end
        load_random();
        begin_frame();
        run_frame(0, 1'b0, DONE_N);
        idle_check();

        // Saturated frame
        for (int i = 0; i < W * H; i++) mem[i] = 8'd255;
        begin_frame();
        run_frame(0, 1'b0, DONE_N);
        idle_check();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
